// File: rtl/sensor_pkg.sv
// Shared widths and signed types for the sensor channel (DCO, ADC front end, demodulator).
// Module parameters default to these constants so the whole channel stays width-consistent.
package sensor_pkg;

    localparam int ADC_DATA_WIDTH_DFLT = 12;
    localparam int REF_DATA_WIDTH_DFLT = 13;
    localparam int WINDOW_BITS_DFLT    = 10;
    localparam int ACC_WIDTH_DFLT      = 36;
    localparam int PROD_WIDTH_DFLT     = ADC_DATA_WIDTH_DFLT + REF_DATA_WIDTH_DFLT;

    // The worst case is (-2^(a-1)) * (-2^(r-1)) summed 2^w times, i.e. +2^(a+r+w-2).
    // Holding that value as a signed number takes a+r+w bits.
    function automatic int min_acc_width(input int adc_w, input int ref_w, input int win_bits);
        return adc_w + ref_w + win_bits;
    endfunction

    typedef logic signed [PROD_WIDTH_DFLT-1:0] prod_t;
    typedef logic signed [ACC_WIDTH_DFLT-1:0]  acc_t;

endpackage

// File: rtl/iq_mac_lane.sv
// One demodulator lane: registered signed product of sample and reference,
// followed by the window accumulator. o_sum is the accumulator including the current product.
module iq_mac_lane
    import sensor_pkg::*;
#(
    parameter int ADC_W = ADC_DATA_WIDTH_DFLT,
    parameter int REF_W = REF_DATA_WIDTH_DFLT,
    parameter int ACC_W = ACC_WIDTH_DFLT
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    i_ce,
    input  logic                    i_restart,
    input  logic                    i_acc_en,
    input  logic                    i_window_end,
    input  logic signed [ADC_W-1:0] i_adc,
    input  logic signed [REF_W-1:0] i_ref_value,
    output logic signed [ACC_W-1:0] o_sum
);

    localparam int PROD_W = ADC_W + REF_W;

    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_prod_ext;

    assign w_prod_ext = ACC_W'(r_prod);
    assign o_sum      = r_acc + w_prod_ext;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prod <= '0;
        end else if (i_ce) begin
            if (i_restart) begin
                r_prod <= '0;
            end else begin
                r_prod <= i_adc * i_ref_value;
            end
        end
    end

    // The last sample of a window goes out through o_sum; the accumulator restarts from zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_acc <= '0;
        end else if (i_ce) begin
            if (i_restart) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                r_acc <= i_window_end ? '0 : o_sum;
            end
        end
    end

endmodule

// File: rtl/iq_demodulator.sv
// I/Q demodulator: input register, two MAC lanes (I uses COS, Q uses SIN), shared window
// counter, and a held output pair with valid/ack handshake and sticky overrun flag.
module iq_demodulator
    import sensor_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = ADC_DATA_WIDTH_DFLT,
    parameter int REF_DATA_WIDTH = REF_DATA_WIDTH_DFLT,
    parameter int WINDOW_BITS    = WINDOW_BITS_DFLT,
    parameter int ACC_WIDTH      = ACC_WIDTH_DFLT
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             CE,
    input  logic                             RESTART,
    input  logic signed [ADC_DATA_WIDTH-1:0] ADC_VALUE,
    input  logic signed [REF_DATA_WIDTH-1:0] SIN_VALUE,
    input  logic signed [REF_DATA_WIDTH-1:0] COS_VALUE,
    output logic signed [ACC_WIDTH-1:0]      I_OUT,
    output logic signed [ACC_WIDTH-1:0]      Q_OUT,
    output logic                             OUT_VALID,
    input  logic                             OUT_ACK,
    output logic                             OVERRUN
);

    logic signed [ADC_DATA_WIDTH-1:0] r_adc;
    logic signed [REF_DATA_WIDTH-1:0] r_sin;
    logic signed [REF_DATA_WIDTH-1:0] r_cos;
    logic                             r_v1;
    logic                             r_v2;
    logic [WINDOW_BITS-1:0]           r_count;

    logic signed [ACC_WIDTH-1:0]      r_i_out;
    logic signed [ACC_WIDTH-1:0]      r_q_out;
    logic                             r_out_valid;
    logic                             r_overrun;

    logic signed [REF_DATA_WIDTH-1:0] w_ref [2];
    logic signed [ACC_WIDTH-1:0]      w_sum [2];
    logic                             w_window_end;
    logic                             w_load;

    // Stage 1: capture the time-aligned sample and references.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_adc <= '0;
            r_sin <= '0;
            r_cos <= '0;
            r_v1  <= 1'b0;
        end else if (CE) begin
            if (RESTART) begin
                r_adc <= '0;
                r_sin <= '0;
                r_cos <= '0;
                r_v1  <= 1'b0;
            end else begin
                r_adc <= ADC_VALUE;
                r_sin <= SIN_VALUE;
                r_cos <= COS_VALUE;
                r_v1  <= 1'b1;
            end
        end
    end

    // Stage 2 valid bit and the window counter, which advances once per accumulated sample.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v2    <= 1'b0;
            r_count <= '0;
        end else if (CE) begin
            if (RESTART) begin
                r_v2    <= 1'b0;
                r_count <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v2) begin
                    r_count <= r_count + WINDOW_BITS'(1);
                end
            end
        end
    end

    assign w_window_end = r_v2 && (r_count == {WINDOW_BITS{1'b1}});
    assign w_load       = CE && !RESTART && w_window_end;

    assign w_ref[0] = r_cos;
    assign w_ref[1] = r_sin;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            iq_mac_lane #(
                .ADC_W (ADC_DATA_WIDTH),
                .REF_W (REF_DATA_WIDTH),
                .ACC_W (ACC_WIDTH)
            ) u_lane (
                .CLK          (CLK),
                .RESET_N      (RESET_N),
                .i_ce         (CE),
                .i_restart    (RESTART),
                .i_acc_en     (r_v2),
                .i_window_end (w_window_end),
                .i_adc        (r_adc),
                .i_ref_value  (w_ref[gi]),
                .o_sum        (w_sum[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_i_out <= '0;
            r_q_out <= '0;
        end else if (w_load) begin
            r_i_out <= w_sum[0];
            r_q_out <= w_sum[1];
        end
    end

    // Handshake runs every clock; a load wins over an ACK in the same cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            if (r_out_valid && !OUT_ACK) begin
                r_overrun <= 1'b1;
            end
        end else if (OUT_ACK) begin
            r_out_valid <= 1'b0;
        end
    end

    assign I_OUT     = r_i_out;
    assign Q_OUT     = r_q_out;
    assign OUT_VALID = r_out_valid;
    assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_iq_demodulator.sv
// Scoreboard bench: a 4-sample-window instance for directed cases and a default-width
// instance for the full-scale 1024-sample window.
module tb_iq_demodulator;
    import sensor_pkg::*;

    typedef struct packed {
        acc_t i;
        acc_t q;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WINDOW_BITS = 2
    logic               rst_n, ce, restart, ack_stim, a_ack;
    logic               ack_mon = 1'b0;
    logic signed [11:0] adc;
    logic signed [12:0] sinv, cosv;
    acc_t               a_i, a_q;
    logic               a_valid, a_overrun;
    assign a_ack = ack_mon | ack_stim;

    // Instance B: defaults
    logic               b_rst_n, b_ce, b_restart;
    logic               b_ack = 1'b0;
    logic signed [11:0] b_adc;
    logic signed [12:0] b_sin, b_cos;
    acc_t               b_i, b_q;
    logic               b_valid, b_overrun;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b1;
    bit   b_done = 1'b0;

    iq_demodulator #(.WINDOW_BITS(2)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .CE(ce), .RESTART(restart),
        .ADC_VALUE(adc), .SIN_VALUE(sinv), .COS_VALUE(cosv),
        .I_OUT(a_i), .Q_OUT(a_q), .OUT_VALID(a_valid), .OUT_ACK(a_ack), .OVERRUN(a_overrun)
    );

    iq_demodulator dut_b (
        .CLK(clk), .RESET_N(b_rst_n), .CE(b_ce), .RESTART(b_restart),
        .ADC_VALUE(b_adc), .SIN_VALUE(b_sin), .COS_VALUE(b_cos),
        .I_OUT(b_i), .Q_OUT(b_q), .OUT_VALID(b_valid), .OUT_ACK(b_ack), .OVERRUN(b_overrun)
    );

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic exp_t mk(input longint i, input longint q);
        exp_t e;
        e.i = acc_t'(i);
        e.q = acc_t'(q);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int a, input int s, input int c);
        adc  = 12'(a);
        sinv = 13'(s);
        cosv = 13'(c);
        step();
    endtask

    // Two zero samples let the last real sample reach the output, then RESTART realigns.
    task automatic flush();
        adc = '0; sinv = '0; cosv = '0;
        step();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // Monitor A: compares every presented result against the queue, then acknowledges it.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && a_valid && !ack_mon) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_a: got I=%0d Q=%0d want no result", a_i, a_q);
            end else begin
                e = q_a.pop_front();
                chk("a_i", a_i, e.i);
                chk("a_q", a_q, e.q);
                $display("A result I=%0d Q=%0d", a_i, a_q);
            end
            ack_mon = 1'b1;
        end else begin
            ack_mon = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_valid && !b_ack) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_b: got I=%0d Q=%0d want no result", b_i, b_q);
            end else begin
                e = q_b.pop_front();
                chk("b_i", b_i, e.i);
                chk("b_q", b_q, e.q);
                $display("B result I=%0d Q=%0d", b_i, b_q);
            end
            b_ack = 1'b1;
        end else begin
            b_ack = 1'b0;
        end
    end

    // Full-scale negative inputs over a 1024-sample window.
    initial begin
        b_rst_n = 1'b0; b_ce = 1'b0; b_restart = 1'b0;
        b_adc = -12'sd2048; b_sin = -13'sd4096; b_cos = -13'sd4096;
        step();
        step();
        b_rst_n = 1'b1;
        b_ce    = 1'b1;
        q_b.push_back(mk(64'd8589934592, 64'd8589934592));
        repeat (1024) step();
        repeat (3) step();
        b_ce   = 1'b0;
        step();
        b_done = 1'b1;
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; restart = 1'b0; ack_stim = 1'b0;
        adc = '0; sinv = '0; cosv = '0;
        step();
        chk("rst_i", a_i, 0);
        chk("rst_q", a_q, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_overrun", a_overrun, 0);
        step();
        rst_n = 1'b1;
        ce    = 1'b1;

        // Constant window plus latency check.
        q_a.push_back(mk(1638000, 0));
        repeat (4) present(100, 0, 4095);
        adc = '0; sinv = '0; cosv = '0;
        step();
        chk("lat_edge2_valid", a_valid, 0);
        step();
        chk("lat_edge3_valid", a_valid, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;

        // Mixed-sign extremes.
        q_a.push_back(mk(-16771014, 16771040));
        present(1, 2, 3);
        present(-5, 7, -11);
        present(2047, 4095, -4096);
        present(-2048, -4096, 4095);
        flush();

        // CE toggling must not lose or duplicate samples.
        q_a.push_back(mk(1638000, -2800));
        adc = 12'sd100; sinv = -13'sd7; cosv = 13'sd4095;
        for (int k = 0; k < 8; k++) begin
            ce = (k % 2 == 0);
            step();
        end
        ce = 1'b1;
        flush();

        // Two windows with no ACK: overwrite and overrun.
        mon_en = 1'b0;
        repeat (4) present(3, 5, 7);
        repeat (4) present(-2, 9, 1);
        adc = '0; sinv = '0; cosv = '0;
        step();
        step();
        chk("ovr_valid", a_valid, 1);
        chk("ovr_i", a_i, -8);
        chk("ovr_q", a_q, -72);
        chk("ovr_flag", a_overrun, 1);
        ack_stim = 1'b1;
        step();
        ack_stim = 1'b0;
        chk("ovr_ack_valid", a_valid, 0);
        chk("ovr_sticky", a_overrun, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;

        // Asynchronous reset between edges in the middle of a window.
        mon_en = 1'b1;
        present(50, 50, 50);
        present(50, 50, 50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_i", a_i, 0);
        chk("rstmid_q", a_q, 0);
        chk("rstmid_valid", a_valid, 0);
        chk("rstmid_overrun", a_overrun, 0);
        #1;
        rst_n = 1'b1;
        q_a.push_back(mk(800, -120));
        repeat (4) present(10, -3, 20);
        flush();

        // ACK coinciding with the completion edge.
        mon_en = 1'b0;
        repeat (4) present(1, 1, 1);
        repeat (4) present(2, 3, 4);
        adc = '0; sinv = '0; cosv = '0;
        step();
        ack_stim = 1'b1;
        step();
        ack_stim = 1'b0;
        chk("ackhit_valid", a_valid, 1);
        chk("ackhit_overrun", a_overrun, 0);
        chk("ackhit_i", a_i, 32);
        chk("ackhit_q", a_q, 24);
        ack_stim = 1'b1;
        step();
        ack_stim = 1'b0;
        chk("ackhit_clear", a_valid, 0);
        restart = 1'b1;
        step();
        restart = 1'b0;

        // RESTART after three samples keeps the pending result.
        repeat (4) present(5, 5, 5);
        adc = '0; sinv = '0; cosv = '0;
        step();
        step();
        chk("rs_pending", a_valid, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (3) present(1000, 1000, 1000);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_valid_kept", a_valid, 1);
        chk("rs_i_kept", a_i, 100);
        repeat (4) present(-3, 4, -6);
        adc = '0; sinv = '0; cosv = '0;
        step();
        step();
        chk("rs_i", a_i, 72);
        chk("rs_q", a_q, -48);
        chk("rs_valid", a_valid, 1);
        chk("rs_overrun", a_overrun, 1);
        ack_stim = 1'b1;
        step();
        ack_stim = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;

        for (int k = 0; k < 3000 && !b_done; k++) step();
        chk("b_done", b_done, 1);
        step();
        step();
        chk("qa_empty", q_a.size(), 0);
        chk("qb_empty", q_b.size(), 0);
        chk("b_overrun", b_overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
